// File: rtl/count_seq_ctrl_pkg.sv
// Shared definitions for the command-driven event counter controller:
// opcode values, FSM state encoding and default widths.
package count_seq_ctrl_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned PRE_W_DEF = 4;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned STATE_W   = 3;

  localparam logic [OP_W-1:0] OP_NOP      = 3'd0;
  localparam logic [OP_W-1:0] OP_LD_START = 3'd1;
  localparam logic [OP_W-1:0] OP_LD_LIMIT = 3'd2;
  localparam logic [OP_W-1:0] OP_LD_PRE   = 3'd3;
  localparam logic [OP_W-1:0] OP_START    = 3'd4;
  localparam logic [OP_W-1:0] OP_STOP     = 3'd5;
  localparam logic [OP_W-1:0] OP_CLEAR    = 3'd6;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/count_tick_gen.sv
// Clock prescaler: pre_cnt advances while enabled and a tick fires when it
// reaches the programmed prescale value.
module count_tick_gen
  import count_seq_ctrl_pkg::*;
#(
  parameter int unsigned PRE_W = PRE_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [PRE_W-1:0] pre_reg_i,
  output logic             tick_c
);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

  assign tick_c = enable_i && (pre_cnt_q == pre_reg_i);

  // clear has priority so a CLEAR landing on a running cycle still zeroes
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clear_i) begin
      pre_cnt_d = '0;
    end else if (enable_i) begin
      pre_cnt_d = tick_c ? '0 : pre_cnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_cnt_q <= '0;
    else        pre_cnt_q <= pre_cnt_d;
  end

endmodule

// File: rtl/count_seq_ctrl.sv
// Event counter sequencer: command decode, config registers, count register
// and the IDLE/LOAD/RUN/HOLD/DONE state machine.
module count_seq_ctrl
  import count_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned PRE_W = PRE_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OP_W-1:0]    cmd_op,
  input  logic [WIDTH-1:0]   cmd_data,
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] state
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             auto_q, auto_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             cmd_acc;
  logic             tick_en;
  logic             tick_clr;
  logic             tick;

  assign cmd_acc = cmd_valid && ready_q;
  assign tick_en = (state_q == ST_RUN);

  count_tick_gen #(.PRE_W(PRE_W)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (tick_en),
    .clear_i  (tick_clr),
    .pre_reg_i(pre_q),
    .tick_c   (tick)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    start_d  = start_q;
    limit_d  = limit_q;
    pre_d    = pre_q;
    auto_d   = auto_q;
    done_d   = 1'b0;
    tick_clr = 1'b0;

    // config loads write registers only; the FSM picks them up later
    if (cmd_acc) begin
      case (cmd_op)
        OP_LD_START: start_d = cmd_data;
        OP_LD_LIMIT: limit_d = cmd_data;
        OP_LD_PRE:   pre_d   = cmd_data[PRE_W-1:0];
        default:     ;
      endcase
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cmd_acc && cmd_op == OP_START) begin
          auto_d  = cmd_data[0];
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d  = start_q;
        tick_clr = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (tick) begin
          if (count_q != limit_q) begin
            count_d = count_q + WIDTH'(1);
          end else begin
            done_d = 1'b1;
            if (auto_q) count_d = start_q;
            else        state_d = ST_DONE;
          end
        end
        // a one-shot terminal tick already chose DONE, which beats STOP
        if (cmd_acc && cmd_op == OP_STOP && state_d == ST_RUN) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cmd_acc && cmd_op == OP_START) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    if (cmd_acc && cmd_op == OP_CLEAR) begin
      state_d  = ST_IDLE;
      count_d  = '0;
      done_d   = 1'b0;
      tick_clr = 1'b1;
    end

    busy_d  = (state_d == ST_LOAD) || (state_d == ST_RUN);
    ready_d = (state_d != ST_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      start_q <= '0;
      limit_q <= '0;
      pre_q   <= '0;
      auto_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      start_q <= start_d;
      limit_q <= limit_d;
      pre_q   <= pre_d;
      auto_q  <= auto_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign count     = count_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state     = state_q;
  assign cmd_ready = ready_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: directed scenarios plus random command traffic,
// all checked against a cycle-level behavioural model.
module tb_count_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_data = 8'd0;
  logic       cmd_ready;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  // reference model state (state codes: 0 idle,1 load,2 run,3 hold,4 done)
  int m_state, m_count, m_start, m_limit, m_pre, m_pc, m_auto, m_done;

  count_seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_count = 0; m_start = 0; m_limit = 0;
    m_pre = 0; m_pc = 0; m_auto = 0; m_done = 0;
  endtask

  task automatic model_step(input logic v, input logic [2:0] op, input logic [7:0] d);
    bit acc, tick;
    int ns, nc, npc, nd;
    acc  = v && (m_state != 1);
    tick = (m_state == 2) && (m_pc == m_pre);
    ns = m_state; nc = m_count; npc = m_pc; nd = 0;
    case (m_state)
      0, 4: if (acc && op == 3'd4) begin m_auto = int'(d[0]); ns = 1; end
      1: begin nc = m_start; npc = 0; ns = 2; end
      2: begin
        npc = tick ? 0 : (m_pc + 1) % 16;
        if (tick) begin
          if (m_count != m_limit) nc = (m_count + 1) % 256;
          else begin
            nd = 1;
            if (m_auto != 0) nc = m_start;
            else ns = 4;
          end
        end
        if (acc && op == 3'd5 && ns == 2) ns = 3;
      end
      3: if (acc && op == 3'd4) ns = 2;
      default: ;
    endcase
    if (acc && op == 3'd6) begin ns = 0; nc = 0; npc = 0; nd = 0; end
    if (acc && op == 3'd1) m_start = int'(d);
    if (acc && op == 3'd2) m_limit = int'(d);
    if (acc && op == 3'd3) m_pre = int'(d[3:0]);
    m_state = ns; m_count = nc; m_pc = npc; m_done = nd;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".count"}, 32'(count), 32'(m_count));
    check_eq({tag, ".state"}, 32'(state), 32'(m_state));
    check_eq({tag, ".done"}, 32'(done), 32'(m_done));
    check_eq({tag, ".busy"}, 32'(busy), 32'((m_state == 1 || m_state == 2) ? 1 : 0));
    check_eq({tag, ".ready"}, 32'(cmd_ready), 32'((m_state != 1) ? 1 : 0));
  endtask

  // drive one command for one clock, advance the model, compare after the edge
  task automatic cycle(input logic v, input logic [2:0] op, input logic [7:0] d, input string tag);
    cmd_valid = v; cmd_op = op; cmd_data = d;
    @(posedge clk);
    model_step(v, op, d);
    #1;
    compare_all(tag);
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".count"}, 32'(count), 32'd0);
    check_eq({tag, ".state"}, 32'(state), 32'd0);
    check_eq({tag, ".busy"}, 32'(busy), 32'd0);
    check_eq({tag, ".done"}, 32'(done), 32'd0);
    check_eq({tag, ".ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    bit found;
    logic [2:0] op;
    logic [7:0] d;
    model_reset();

    // reset defaults
    @(posedge clk); #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // one-shot 5..8
    cycle(1, 3'd1, 8'd5, "os_ld");
    cycle(1, 3'd2, 8'd8, "os_ld");
    cycle(1, 3'd3, 8'd0, "os_ld");
    cycle(1, 3'd4, 8'd0, "os_start");
    check_eq("os_load_state", 32'(state), 32'd1);
    for (int i = 5; i <= 8; i++) begin
      cycle(0, 3'd0, 8'd0, "os_run");
      check_eq("os_seq", 32'(count), 32'(i));
    end
    cycle(0, 3'd0, 8'd0, "os_term");
    check_eq("os_done_pulse", 32'(done), 32'd1);
    check_eq("os_done_state", 32'(state), 32'd4);
    cycle(0, 3'd0, 8'd0, "os_after");
    check_eq("os_done_clr", 32'(done), 32'd0);
    check_eq("os_hold_limit", 32'(count), 32'd8);

    // auto-reload across the wrap with prescale 2
    cycle(1, 3'd6, 8'd0, "ar_clr");
    cycle(1, 3'd1, 8'd250, "ar_ld");
    cycle(1, 3'd2, 8'd2, "ar_ld");
    cycle(1, 3'd3, 8'd2, "ar_ld");
    cycle(1, 3'd4, 8'd1, "ar_start");
    cycle(0, 3'd0, 8'd0, "ar_load");
    check_eq("ar_first", 32'(count), 32'd250);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle(0, 3'd0, 8'd0, "ar_run");
      if (done === 1'b1) begin
        found = 1;
        check_eq("ar_done_cycle", 32'(i), 32'd26);
      end
    end
    check_eq("ar_done_seen", 32'(found), 32'd1);
    check_eq("ar_reload", 32'(count), 32'd250);
    check_eq("ar_state_run", 32'(state), 32'd2);

    // hold/resume: stop so that count=6, pre_cnt=1 are frozen
    cycle(1, 3'd6, 8'd0, "hr_clr");
    cycle(1, 3'd1, 8'd3, "hr_ld");
    cycle(1, 3'd2, 8'd20, "hr_ld");
    cycle(1, 3'd4, 8'd0, "hr_start");
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_state == 2 && m_count == 6 && m_pc == 0) found = 1;
      else cycle(0, 3'd0, 8'd0, "hr_run");
    end
    check_eq("hr_reach6", 32'(found), 32'd1);
    cycle(1, 3'd5, 8'd0, "hr_stop");
    check_eq("hr_state_hold", 32'(state), 32'd3);
    for (int i = 0; i < 10; i++) cycle(0, 3'd0, 8'd0, "hr_frozen");
    check_eq("hr_frozen_cnt", 32'(count), 32'd6);
    cycle(1, 3'd4, 8'd0, "hr_resume");
    cycle(0, 3'd0, 8'd0, "hr_r1");
    check_eq("hr_not_yet", 32'(count), 32'd6);
    cycle(0, 3'd0, 8'd0, "hr_r2");
    check_eq("hr_incr", 32'(count), 32'd7);

    // STOP on one-shot terminal tick: DONE wins
    cycle(1, 3'd3, 8'd0, "st_pre0");
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_state == 2 && m_count == 20 && m_pc == m_pre) found = 1;
      else cycle(0, 3'd0, 8'd0, "st_run");
    end
    check_eq("st_reach", 32'(found), 32'd1);
    cycle(1, 3'd5, 8'd0, "st_stop_term");
    check_eq("st_state_done", 32'(state), 32'd4);
    check_eq("st_done_pulse", 32'(done), 32'd1);

    // CLEAR on a tick (pre 0 ticks every cycle, auto-reload run)
    cycle(1, 3'd4, 8'd1, "cl_start");
    cycle(0, 3'd0, 8'd0, "cl_load");
    cycle(0, 3'd0, 8'd0, "cl_run");
    cycle(1, 3'd6, 8'd0, "cl_clear");
    check_eq("cl_state", 32'(state), 32'd0);
    check_eq("cl_count", 32'(count), 32'd0);
    check_eq("cl_done", 32'(done), 32'd0);

    // command held across LOAD is only taken in RUN
    cycle(1, 3'd4, 8'd0, "hs_start");
    check_eq("hs_ready_low", 32'(cmd_ready), 32'd0);
    cycle(1, 3'd1, 8'd77, "hs_in_load");
    cycle(1, 3'd1, 8'd77, "hs_in_run");
    check_eq("hs_taken", 32'(m_start), 32'd77);

    // asynchronous reset mid-RUN
    cycle(0, 3'd0, 8'd0, "rs_run");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      op = 3'($urandom_range(0, 7));
      if ((op == 3'd6 || op == 3'd5) && $urandom_range(0, 3) != 0) op = 3'd0;
      d = 8'($urandom_range(0, 255));
      if (op == 3'd2) d = 8'(m_start + int'($urandom_range(0, 6)));
      if (op == 3'd3) d = 8'($urandom_range(0, 3));
      cycle(($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0, op, d, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
